// File: rtl/mem_arb.sv
// Memory arbiter between the fetch and data ports of the CPU. One access is in flight at a time.
// The memory side is latched at grant, and the access ends on m_ack or after TMO cycles without it.
module mem_arb #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int TMO = 15
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [4:0]    phase,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          i_done,
    output logic          d_done,
    output logic [DW-1:0] i_rdata,
    output logic [DW-1:0] d_rdata,
    output logic          stall,
    output logic          bus_err
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t     state, state_nxt;
    logic       iq, dq, grant_ok, tmo_hit;
    logic [7:0] cnt;

    assign iq       = i_req & phase[0];
    assign dq       = d_req & phase[3];
    // No grant while a done pulse is out, which forces one IDLE cycle between accesses.
    assign grant_ok = ~i_done & ~d_done;
    assign tmo_hit  = ~m_ack && (cnt == 8'(TMO - 1));
    assign m_req    = (state != IDLE);
    assign stall    = (iq | dq) & ~(i_done | d_done);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    if (dq)      state_nxt = DACC;
                    else if (iq) state_nxt = IACC;
                end
            end
            IACC, DACC: begin
                if (m_ack || tmo_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == DACC) begin
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        cnt     <= '0;
                    end else if (state_nxt == IACC) begin
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                        cnt     <= '0;
                    end
                end
                IACC, DACC: begin
                    if (m_ack) begin
                        if (state == DACC) begin
                            d_done <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else if (tmo_hit) begin
                        bus_err <= 1'b1;
                        if (state == DACC) begin
                            d_done  <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
